ram_responder: RTL and testbench
================================

RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter LAT, default 2, meaning BUSY cycles per access before ACCESS; legal range 1..15.
REQ-002 Parameter DEPTH, default 1024, meaning number of 32-bit words stored.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 ramREN  input  1  read request from memory_control.
REQ-006 ramWEN  input  1  write request from memory_control.
REQ-007 ramaddr  input  32 (word_t)  byte address.
REQ-008 ramstore  input  32 (word_t)  write data.
REQ-009 ramload  output  32 (word_t)  read data; valid only while ramstate==ACCESS on a read.
REQ-010 ramstate  output  ramstate_t  FREE/BUSY/ACCESS/ERROR.
REQ-011 rd_count  output  16  completed reads, saturating.
REQ-012 wr_count  output  16  completed writes, saturating.

Function
REQ-013 The internal FSM SHALL have states IDLE, WAIT, ACC, ERR.
REQ-014 A request SHALL be ramREN xor ramWEN with a legal address.
REQ-015 A legal address SHALL have ramaddr[1:0]==0 and ramaddr[31:2] < DEPTH.
REQ-016 ERROR condition: ramREN and ramWEN both high, or either high with an illegal address.
REQ-017 ERROR SHALL take priority over all states; ramstate=ERROR combinationally for as long as the condition holds; next state ERR, then IDLE once it clears.
REQ-018 In ERR, memory and counters SHALL NOT change, and ramload SHALL be 0.
REQ-019 With no request and no error, ramstate SHALL be FREE and ramload 0.
REQ-020 Each request SHALL see exactly LAT consecutive BUSY cycles, starting with the cycle it is first asserted, then exactly one ACCESS cycle.
REQ-021 On entering WAIT, the FSM SHALL latch the address and the read/write direction.
REQ-022 A change in ramaddr or direction during WAIT or ACC SHALL restart the access; the change cycle counts as BUSY cycle 1.
REQ-023 Request deasserted during WAIT SHALL abort the access: FREE that cycle, next state IDLE, no write, no count.
REQ-024 In ACC on a read, ramload SHALL equal mem[ramaddr[31:2]] combinationally.
REQ-025 In ACC on a write, mem[ramaddr[31:2]] SHALL take ramstore at the rising edge that ends the cycle.
REQ-026 Read-after-write to the same word SHALL return the new data in the next access.
REQ-027 After ACC, a still-asserted request SHALL begin a fresh access (BUSY again); this is a new transaction, not a hold.
REQ-028 rd_count / wr_count SHALL increment by 1 at the edge ending each ACC read/write.
REQ-029 rd_count / wr_count SHALL hold at 16'hFFFF when saturated.
REQ-030 The latency counter SHALL be 4 bits wide and SHALL never wrap below zero.

Reset
REQ-031 While RST is high: state=IDLE, latency counter=0, ramstate=FREE, ramload=0, rd_count=0, wr_count=0, all memory words 0.
REQ-032 RST asserted mid-access SHALL abort the access immediately; no partial write occurs.
REQ-033 The first request after RST deasserts SHALL see the full LAT BUSY cycles.

Structure
REQ-034 ramstate_t (FREE, BUSY, ACCESS, ERROR) and word_t SHALL come from cpu_types_pkg.
REQ-035 A constant RAM_LAT_DEFAULT=2 SHALL be added to cpu_types_pkg.
REQ-036 The FSM type SHALL be local to the module.
REQ-037 Storage SHALL be one sub-module, ram_array:
- combinational read;
- synchronous write-enable;
- asynchronous clear on RST.

Verification
REQ-038 Read test, LAT=2: preload word 4 = 32'hDEADBEEF; ramREN=1, ramaddr=32'h10 -> BUSY, BUSY, ACCESS with ramload=32'hDEADBEEF; rd_count=1.
REQ-039 Write/readback test, LAT=2: ramWEN=1, ramaddr=32'h20, ramstore=32'hCAFEF00D held to ACCESS; then read 32'h20 -> ACCESS ramload=32'hCAFEF00D; wr_count=1, rd_count=1.
REQ-040 Address-change test: ramaddr 32'h10 -> 32'h14 in second BUSY cycle -> two further BUSY cycles, then ACCESS with data of word 5.
REQ-041 Error test: ramREN=ramWEN=1 -> ERROR and ramload=0 that cycle; then ramaddr=32'h3 with ramREN=1 -> ERROR; then ramaddr=4*DEPTH -> ERROR; memory and counts unchanged throughout.
REQ-042 Abort/reset test: write starts, ramWEN drops after 1 BUSY -> FREE, target word unchanged; new write with RST pulsed in its BUSY -> all outputs reset, memory 0.
REQ-043 Saturation test: force 65536 reads -> rd_count stays 16'hFFFF.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: word type, RAM handshake state and RAM defaults.
package cpu_types_pkg;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned RAM_LAT_DEFAULT = 2;
  localparam int unsigned RAM_LAT_W       = 4;
  localparam int unsigned RAM_CNT_W       = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/ram_array.sv
// Word storage: combinational read, synchronous write, asynchronous clear.
module ram_array
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  word_t         wdata,
  input  logic [AW-1:0] raddr,
  output word_t         rdata
);

  word_t mem [DEPTH];

  // Clear every word on reset, otherwise write one word when enabled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ram_responder.sv
// Latency-modelling RAM slave for memory_control: BUSY for LAT cycles, then one ACCESS.
module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int unsigned LAT   = RAM_LAT_DEFAULT,
  parameter int unsigned DEPTH = 1024
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ramREN,
  input  logic                 ramWEN,
  input  word_t                ramaddr,
  input  word_t                ramstore,
  output word_t                ramload,
  output ramstate_t            ramstate,
  output logic [RAM_CNT_W-1:0] rd_count,
  output logic [RAM_CNT_W-1:0] wr_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [RAM_LAT_W-1:0] LAT_M1 = RAM_LAT_W'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACC  = 2'd2,
    ERR  = 2'd3
  } fsm_t;

  fsm_t                 state;
  logic [RAM_LAT_W-1:0] lat_cnt;
  word_t                lat_addr;
  logic                 lat_wr;
  logic [RAM_CNT_W-1:0] rd_cnt_q;
  logic [RAM_CNT_W-1:0] wr_cnt_q;

  logic  legal_c;
  logic  err_c;
  logic  req_c;
  logic  same_c;
  logic  acc_c;
  logic  rd_acc_c;
  logic  wr_acc_c;
  word_t rdata;

  // Request classification against the current bus and the latched transaction.
  always_comb begin
    legal_c  = (ramaddr[1:0] == 2'b00) && (ramaddr[31:2] < 30'(DEPTH));
    err_c    = (ramREN & ramWEN) | ((ramREN | ramWEN) & ~legal_c);
    req_c    = (ramREN ^ ramWEN) & legal_c;
    same_c   = (ramaddr == lat_addr) && (ramWEN == lat_wr);
    acc_c    = (state == ACC) && req_c && same_c;
    rd_acc_c = acc_c & ~lat_wr;
    wr_acc_c = acc_c & lat_wr;
  end

  // Handshake outputs decode live from the bus so errors and new requests show at once.
  always_comb begin
    ramstate = FREE;
    ramload  = '0;
    if (RST) begin
      ramstate = FREE;
    end else if (err_c) begin
      ramstate = ERROR;
    end else if (req_c) begin
      if (acc_c) begin
        ramstate = ACCESS;
        if (!lat_wr) begin
          ramload = rdata;
        end
      end else begin
        ramstate = BUSY;
      end
    end
  end

  // Access FSM; any new or changed request restarts the latency count as BUSY cycle 1.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      lat_addr <= '0;
      lat_wr   <= 1'b0;
    end else if (err_c) begin
      state   <= ERR;
      lat_cnt <= '0;
    end else if (!req_c) begin
      state   <= IDLE;
      lat_cnt <= '0;
    end else if (state == WAIT && same_c) begin
      if (lat_cnt <= RAM_LAT_W'(1)) begin
        state   <= ACC;
        lat_cnt <= '0;
      end else begin
        lat_cnt <= lat_cnt - RAM_LAT_W'(1);
      end
    end else if (state == ACC && same_c) begin
      // Transaction done; a held request starts afresh next cycle.
      state   <= IDLE;
      lat_cnt <= '0;
    end else begin
      lat_addr <= ramaddr;
      lat_wr   <= ramWEN;
      lat_cnt  <= LAT_M1;
      state    <= (LAT_M1 == '0) ? ACC : WAIT;
    end
  end

  // Saturating completion counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (rd_acc_c && (rd_cnt_q != '1)) begin
        rd_cnt_q <= rd_cnt_q + RAM_CNT_W'(1);
      end
      if (wr_acc_c && (wr_cnt_q != '1)) begin
        wr_cnt_q <= wr_cnt_q + RAM_CNT_W'(1);
      end
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;

  ram_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram_array (
    .CLK   (CLK),
    .RST   (RST),
    .we    (wr_acc_c),
    .waddr (ramaddr[AW+1:2]),
    .wdata (ramstore),
    .raddr (ramaddr[AW+1:2]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: transaction-level model feeds an expectation queue.
module tb_ram_responder;
  import cpu_types_pkg::*;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 1024;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ramREN = 1'b0;
  logic        ramWEN = 1'b0;
  word_t       ramaddr = '0;
  word_t       ramstore = '0;
  word_t       ramload;
  ramstate_t   ramstate;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  ram_responder #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .rd_count (rd_count),
    .wr_count (wr_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          cyc;
    ramstate_t   st;
    word_t       load;
    logic [15:0] rd;
    logic [15:0] wr;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference model: memory image plus one in-flight transaction.
  word_t       m_mem [DEPTH];
  logic [15:0] m_rd = '0;
  logic [15:0] m_wr = '0;
  bit          t_active = 0;
  word_t       t_addr = '0;
  bit          t_wr = 0;
  int          t_seen = 0;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Drive one cycle of inputs and queue what the spec says this cycle must show.
  task automatic step(input bit r, input bit re, input bit we, input word_t a, input word_t d);
    exp_t e;
    bit   legal;
    bit   err;
    @(posedge CLK);
    #1;
    RST = r; ramREN = re; ramWEN = we; ramaddr = a; ramstore = d;
    cyc++;
    e.cyc = cyc;
    e.load = '0;
    if (r) begin
      for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
      m_rd = '0; m_wr = '0; t_active = 0;
      e.st = FREE; e.rd = '0; e.wr = '0;
    end else begin
      legal = (a % 4 == 0) && ((a / 4) < DEPTH);
      err   = (re && we) || ((re || we) && !legal);
      e.rd = m_rd; e.wr = m_wr;
      if (err) begin
        e.st = ERROR; t_active = 0;
      end else if (!(re || we)) begin
        e.st = FREE; t_active = 0;
      end else if (t_active && a == t_addr && we == t_wr) begin
        if (t_seen == int'(LAT)) begin
          e.st = ACCESS;
          if (we) begin
            m_mem[a / 4] = d; m_wr = sat_inc(m_wr);
          end else begin
            e.load = m_mem[a / 4]; m_rd = sat_inc(m_rd);
          end
          t_active = 0;
        end else begin
          e.st = BUSY; t_seen++;
        end
      end else begin
        e.st = BUSY; t_active = 1; t_addr = a; t_wr = we; t_seen = 1;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int c, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, c, got, want);
    end
  endtask

  // Monitor: every cycle the DUT presents a state; pop and compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ramstate", e.cyc, 32'(ramstate), 32'(e.st));
        chk("ramload",  e.cyc, ramload, e.load);
        chk("rd_count", e.cyc, 32'(rd_count), 32'(e.rd));
        chk("wr_count", e.cyc, 32'(wr_count), 32'(e.wr));
      end
    end
  end

  task automatic txn(input bit we, input word_t a, input word_t d);
    for (int i = 0; i <= int'(LAT); i++) step(0, !we, we, a, d);
  endtask

  task automatic idle();
    step(0, 0, 0, '0, '0);
  endtask

  initial begin
    bit    cre, cwe;
    word_t ca, cd;
    int    r;
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;

    step(1, 0, 0, '0, '0);
    step(1, 1, 0, 32'h10, '0);

    // Preload words 4 and 5, then read word 4.
    txn(1, 32'h10, 32'hDEADBEEF);
    idle();
    txn(1, 32'h14, 32'h55AA33CC);
    idle();
    txn(0, 32'h10, '0);
    idle();

    // Write then read back.
    txn(1, 32'h20, 32'hCAFEF00D);
    txn(0, 32'h20, '0);
    idle();

    // Address change mid-wait restarts the latency.
    step(0, 1, 0, 32'h10, '0);
    txn(0, 32'h14, '0);
    idle();

    // Error patterns leave memory and counts alone.
    step(0, 1, 1, 32'h10, 32'h11111111);
    step(0, 1, 0, 32'h3, '0);
    step(0, 0, 1, 32'(4 * DEPTH), 32'h22222222);
    idle();
    txn(0, 32'h10, '0);
    txn(0, 32'h20, '0);

    // Aborted write, then reset during a write.
    step(0, 0, 1, 32'h30, 32'h12345678);
    idle();
    txn(0, 32'h30, '0);
    step(0, 0, 1, 32'h30, 32'h12345678);
    step(1, 0, 1, 32'h30, 32'h12345678);
    txn(0, 32'h10, '0);
    txn(0, 32'h30, '0);

    // Randomized traffic over a small address window.
    cre = 1; cwe = 0; ca = 32'h0; cd = '0;
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 68) begin
        // hold current request
      end else if (r < 80) begin
        cwe = 1'($urandom_range(0, 1)); cre = !cwe;
        ca = 32'($urandom_range(0, 15)) * 4; cd = $urandom;
      end else if (r < 87) begin
        cre = 0; cwe = 0;
      end else if (r < 91) begin
        case ($urandom_range(0, 2))
          0: begin cre = 1; cwe = 1; end
          1: begin cre = 1; cwe = 0; ca = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3)); end
          default: begin cre = 0; cwe = 1; ca = 32'(4 * DEPTH) + 32'($urandom_range(0, 15)) * 4; end
        endcase
      end else if (r < 94) begin
        cd = $urandom;
      end else if (r < 96) begin
        step(1, cre, cwe, ca, cd);
        continue;
      end else begin
        if (cre ^ cwe) begin cre = !cre; cwe = !cwe; end
      end
      step(0, cre, cwe, ca, cd);
    end
    idle();

    // Saturation: preset both counters just below the top, then overrun them.
    @(posedge CLK);
    #2;
    force dut.rd_cnt_q = 16'hFFFD;
    force dut.wr_cnt_q = 16'hFFFD;
    #1;
    release dut.rd_cnt_q;
    release dut.wr_cnt_q;
    m_rd = 16'hFFFD;
    m_wr = 16'hFFFD;
    for (int k = 0; k < 4; k++) begin
      txn(0, 32'h40, '0);
      txn(1, 32'h44, 32'(k));
    end
    idle();
    idle();

    repeat (3) @(posedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
